// File: rtl/motor_pwm_drive.sv
// Per-motor H-bridge driver: prescaled PWM plus direction pins. New speeds take
// effect only on period boundaries, and every reversal passes through a dead time.
module motor_pwm_drive #(
    parameter int PRESCALE = 4,
    parameter int CNT_BITS = 8,
    parameter int DEADTIME = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [8:0] speed,
    input  logic       speed_valid,
    output logic       pwm,
    output logic       dirp,
    output logic       dirn,
    output logic       busy,
    output logic       period_end
);

    // state | meaning
    // STOP  | bridge off, counter free-running while enabled
    // FWD   | dirp=1, PWM from active magnitude
    // REV   | dirn=1, PWM from active magnitude
    // DEAD  | both halves off for DEADTIME clks before a reversal completes
    typedef enum logic [1:0] {ST_STOP, ST_FWD, ST_REV, ST_DEAD} state_t;

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam int CW = (CNT_BITS > 8) ? CNT_BITS : 8;
    localparam logic [PW-1:0]       PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [CNT_BITS-1:0] CNT_LAST  = '1;
    localparam logic [DW-1:0]       DEAD_LOAD = DW'(DEADTIME - 1);

    state_t              state;
    state_t              tgt_dir;
    state_t              pend_dir;
    logic [7:0]          pend_mag;
    logic [7:0]          act_mag;
    logic [PW-1:0]       presc;
    logic [CNT_BITS-1:0] cnt;
    logic [DW-1:0]       dead_cnt;

    logic [8:0]  neg_speed;
    logic [7:0]  spd_mag;
    state_t      spd_dir;
    logic        tick;
    logic        reversal;
    logic        dir_active;
    logic        pwm_cmp;

    // -256 has no 8-bit magnitude, so it saturates to 255
    always_comb begin
        neg_speed = 9'd0 - speed;
        spd_mag   = speed[7:0];
        spd_dir   = ST_STOP;
        if (speed[8]) begin
            spd_mag = neg_speed[8] ? 8'hFF : neg_speed[7:0];
            spd_dir = ST_REV;
        end else if (speed != 9'd0) begin
            spd_dir = ST_FWD;
        end
    end

    assign tick       = en && (state != ST_DEAD) && (presc == PRE_LAST);
    assign period_end = tick && (cnt == CNT_LAST);
    assign reversal   = ((state == ST_FWD) && (pend_dir == ST_REV)) ||
                        ((state == ST_REV) && (pend_dir == ST_FWD));
    assign dir_active = (state == ST_FWD) || (state == ST_REV);
    assign pwm_cmp    = CW'(cnt) < CW'(act_mag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_STOP;
            tgt_dir  <= ST_STOP;
            pend_dir <= ST_STOP;
            pend_mag <= '0;
            act_mag  <= '0;
            presc    <= '0;
            cnt      <= '0;
            dead_cnt <= '0;
            pwm      <= 1'b0;
            dirp     <= 1'b0;
            dirn     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            // A strobe coinciding with period_end lands after the boundary
            // has already sampled pend_*, so it is deferred one period.
            if (speed_valid) begin
                pend_mag <= spd_mag;
                pend_dir <= spd_dir;
            end

            if (!en) begin
                state   <= ST_STOP;
                presc   <= '0;
                cnt     <= '0;
                act_mag <= '0;
                pwm     <= 1'b0;
                dirp    <= 1'b0;
                dirn    <= 1'b0;
                busy    <= 1'b0;
            end else begin
                pwm <= dir_active && pwm_cmp;
                case (state)
                    ST_DEAD: begin
                        if (dead_cnt == '0) begin
                            state <= tgt_dir;
                            dirp  <= (tgt_dir == ST_FWD);
                            dirn  <= (tgt_dir == ST_REV);
                            busy  <= 1'b0;
                        end else begin
                            dead_cnt <= dead_cnt - 1'b1;
                        end
                    end
                    default: begin
                        presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
                        if (tick) begin
                            cnt <= cnt + 1'b1;
                        end
                        if (period_end) begin
                            act_mag <= pend_mag;
                            if (reversal) begin
                                state    <= ST_DEAD;
                                tgt_dir  <= pend_dir;
                                dead_cnt <= DEAD_LOAD;
                                presc    <= '0;
                                cnt      <= '0;
                                dirp     <= 1'b0;
                                dirn     <= 1'b0;
                                busy     <= 1'b1;
                            end else begin
                                state <= pend_dir;
                                dirp  <= (pend_dir == ST_FWD);
                                dirn  <= (pend_dir == ST_REV);
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_motor_pwm_drive.sv
// Bench for motor_pwm_drive: a period-phase model predicts every output each cycle,
// directed scenarios pin pulse widths and dead time, then randomized strobes follow.
module tb_motor_pwm_drive;

    localparam int P   = 4;
    localparam int CB  = 8;
    localparam int DT  = 16;
    localparam int PER = P * (1 << CB);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [8:0] speed = '0;
    logic       speed_valid = 1'b0;
    logic       pwm, dirp, dirn, busy, period_end;

    int checks = 0;
    int failures = 0;

    motor_pwm_drive #(.PRESCALE(P), .CNT_BITS(CB), .DEADTIME(DT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .speed(speed), .speed_valid(speed_valid),
        .pwm(pwm), .dirp(dirp), .dirn(dirn), .busy(busy), .period_end(period_end)
    );

    always #5 clk = ~clk;

    // Model: mode 0 stop, 1 fwd, 2 rev, 3 dead; ph = clks elapsed in current period;
    // speeds held as signed clamped integers.
    int m_mode, m_ph, m_act, m_pend, m_tgt, m_dead;
    logic e_pwm, e_dirp, e_dirn, e_busy;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int clamp_speed(input logic [8:0] s);
        int v;
        v = $signed(s);
        return (v < -255) ? -255 : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_ph = 0; m_act = 0; m_pend = 0; m_tgt = 0; m_dead = 0;
            e_pwm = 0; e_dirp = 0; e_dirn = 0; e_busy = 0;
        end else begin
            e_pwm = en && (m_mode == 1 || m_mode == 2) && ((m_ph / P) < iabs(m_act));
            if (!en) begin
                m_mode = 0; m_ph = 0; m_act = 0;
            end else if (m_mode == 3) begin
                m_dead = m_dead - 1;
                if (m_dead == 0) begin
                    m_mode = (m_tgt > 0) ? 1 : 2;
                    m_act  = m_tgt;
                    m_ph   = 0;
                end
            end else if (m_ph == PER - 1) begin
                m_ph = 0;
                if ((m_mode == 1 && m_pend < 0) || (m_mode == 2 && m_pend > 0)) begin
                    m_mode = 3; m_dead = DT; m_tgt = m_pend;
                end else begin
                    m_act  = m_pend;
                    m_mode = (m_pend > 0) ? 1 : ((m_pend < 0) ? 2 : 0);
                end
            end else begin
                m_ph = m_ph + 1;
            end
            if (speed_valid) m_pend = clamp_speed(speed);
            e_dirp = (m_mode == 1);
            e_dirn = (m_mode == 2);
            e_busy = (m_mode == 3);
        end
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("pwm", pwm, e_pwm);
        chk("dirp", dirp, e_dirp);
        chk("dirn", dirn, e_dirn);
        chk("busy", busy, e_busy);
        chk("period_end", period_end, en && (m_mode != 3) && (m_ph == PER - 1));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic strobe(input int s);
        speed = 9'(s);
        speed_valid = 1'b1;
        step();
        speed_valid = 1'b0;
    endtask

    task automatic wait_pe(input string nm, input int lim);
        int n;
        n = 0;
        while (!period_end && n < lim) begin
            step();
            n++;
        end
        if (!period_end) begin
            failures++;
            $display("FAIL %s: no period_end within %0d clks", nm, lim);
        end
    endtask

    // Counts pwm-high clks over the period that starts at the next edge.
    task automatic measure_high(output int hi);
        hi = 0;
        repeat (PER) begin
            step();
            speed_valid = 1'b0;
            hi += int'(pwm);
        end
    endtask

    int hi, busyc, n;

    initial begin
        repeat (3) step();
        chk("rst_pwm", pwm, 1'b0);
        chk("rst_dirp", dirp, 1'b0);
        chk("rst_dirn", dirn, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        step();

        // forward +64
        en = 1'b1;
        strobe(64);
        wait_pe("t2_wait", PER + 10);
        measure_high(hi);
        chk_int("t2_high_clks_a", hi, 256);
        measure_high(hi);
        chk_int("t2_high_clks_b", hi, 256);
        chk("t2_dirp", dirp, 1'b1);
        chk("t2_dirn", dirn, 1'b0);

        // async reset mid-pulse
        repeat (100) step();
        chk("t1_pre_pwm", pwm, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("t1_pwm", pwm, 1'b0);
        chk("t1_dirp", dirp, 1'b0);
        chk("t1_busy", busy, 1'b0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        strobe(64);
        wait_pe("t1_wait", PER + 10);
        measure_high(hi);
        chk_int("t1_restart_high", hi, 256);

        // reversal +64 -> -32 via dead time
        repeat (10) step();
        strobe(-32);
        wait_pe("t3_wait", PER + 10);
        busyc = 0;
        repeat (40) begin
            step();
            busyc += int'(busy);
        end
        chk_int("t3_dead_clks", busyc, DT);
        wait_pe("t3_wait2", PER + 10);
        measure_high(hi);
        chk_int("t3_high_clks", hi, 128);
        chk("t3_dirn", dirn, 1'b1);

        // clamp -256 -> 255
        repeat (10) step();
        strobe(-256);
        wait_pe("t4_wait", PER + 10);
        measure_high(hi);
        chk_int("t4_low_clks", PER - hi, P);

        // last strobe wins; coincident strobe deferred
        repeat (50) step();
        strobe(10);
        repeat (200) step();
        strobe(200);
        wait_pe("t5_wait", PER + 10);
        repeat (40) step();
        wait_pe("t5_wait2", PER + 10);
        speed = 9'd100;
        speed_valid = 1'b1;
        measure_high(hi);
        chk_int("t5_high_200", hi, 800);
        wait_pe("t5_wait3", PER + 10);
        measure_high(hi);
        chk_int("t5_high_100", hi, 400);

        // drop enable mid-pulse, re-enable into reverse
        n = 0;
        while (!pwm && n < PER) begin
            step();
            n++;
        end
        chk("t6_pre_pwm", pwm, 1'b1);
        en = 1'b0;
        step();
        chk("t6_pwm_off", pwm, 1'b0);
        chk("t6_dirp_off", dirp, 1'b0);
        strobe(-50);
        repeat (20) step();
        en = 1'b1;
        busyc = 0;
        repeat (PER - 1) begin
            step();
            busyc += int'(busy);
        end
        chk("t6_dirn_early", dirn, 1'b0);
        step();
        chk("t6_dirn", dirn, 1'b1);
        chk_int("t6_no_dead", busyc + int'(busy), 0);
        wait_pe("t6_wait", PER + 10);
        measure_high(hi);
        chk_int("t6_high_clks", hi, 200);

        // randomized strobes, enable drops and resets
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                en = 1'b0;
                repeat ($urandom_range(1, 30)) step();
                en = 1'b1;
            end else if (r == 1) begin
                #1 rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else if (r == 2) begin
                strobe(($urandom_range(0, 1) == 1) ? -256 : 255);
            end else if (r == 3) begin
                strobe(0);
            end else begin
                strobe(int'($urandom_range(0, 511)) - 256);
            end
            repeat ($urandom_range(1, 1500)) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
